// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared types and byte-0 bit positions for the PS/2 mouse packet decoder
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } ps2_state_t;

    localparam int B0_L    = 0;
    localparam int B0_R    = 1;
    localparam int B0_M    = 2;
    localparam int B0_SYNC = 3;
    localparam int B0_XSGN = 4;
    localparam int B0_YSGN = 5;
    localparam int B0_XOVF = 6;
    localparam int B0_YOVF = 7;

    // {M, R, L}
    typedef logic [2:0] buttons_t;

endpackage

// File: rtl/ps2_mouse_axis_mag.sv
// rtl/ps2_mouse_axis_mag.sv - 9-bit two's complement axis to saturated 8-bit magnitude plus sign
module ps2_mouse_axis_mag (
    input  logic       sign,
    input  logic [7:0] data,
    input  logic       ovf,
    output logic [7:0] mag,
    output logic       neg
);

    logic [8:0] neg_val;

    always_comb begin
        neg_val = 9'd0;
        mag     = data;
        neg     = sign;
        if (ovf) begin
            mag = 8'hFF;
        end else if (sign) begin
            // Only -256 (data 0x00) negates to 9'h100, which clamps to 255.
            neg_val = (~{1'b1, data}) + 9'd1;
            mag     = neg_val[8] ? 8'hFF : neg_val[7:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// rtl/ps2_mouse_packet_decoder.sv - assembles PS/2 mouse bytes into packets; PS2_MOUSE_DEADZONE_EN enables the deadzone
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEADZONE       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic [7:0] o_mouse_dx,
    output logic [7:0] o_mouse_dy,
    output logic       o_is_mouse_dx_neg,
    output logic       o_is_mouse_dy_neg,
    output logic [2:0] o_buttons,
    output logic       o_packet_valid,
    output logic       o_sync_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

`ifdef PS2_MOUSE_DEADZONE_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif
    localparam logic [8:0] DZ_THRESH = DZ_EN ? 9'(DEADZONE) : 9'd0;

    ps2_state_t       state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [7:0]       b0_q, b0_d;
    logic [7:0]       x_q, x_d;
    logic [7:0]       dx_q, dx_d;
    logic [7:0]       dy_q, dy_d;
    logic             dx_neg_q, dx_neg_d;
    logic             dy_neg_q, dy_neg_d;
    buttons_t         buttons_q, buttons_d;
    logic             packet_valid_q, packet_valid_d;
    logic             sync_err_q, sync_err_d;

    logic             timeout;
    ps2_state_t       eff_state;
    logic [7:0]       x_mag, y_mag;
    logic             x_neg, y_neg;
    logic [7:0]       x_mag_dz, y_mag_dz;

    ps2_mouse_axis_mag u_x_mag (
        .sign (b0_q[B0_XSGN]),
        .data (x_q),
        .ovf  (b0_q[B0_XOVF]),
        .mag  (x_mag),
        .neg  (x_neg)
    );

    ps2_mouse_axis_mag u_y_mag (
        .sign (b0_q[B0_YSGN]),
        .data (i_byte),
        .ovf  (b0_q[B0_YOVF]),
        .mag  (y_mag),
        .neg  (y_neg)
    );

    assign x_mag_dz = ({1'b0, x_mag} < DZ_THRESH) ? 8'd0 : x_mag;
    assign y_mag_dz = ({1'b0, y_mag} < DZ_THRESH) ? 8'd0 : y_mag;

    // A byte arriving on the timeout cycle is judged as a fresh byte 0.
    assign timeout   = (state_q != WAIT_B0) && (idle_q == CNT_MAX);
    assign eff_state = timeout ? WAIT_B0 : state_q;

    always_comb begin
        state_d        = eff_state;
        b0_d           = b0_q;
        x_d            = x_q;
        dx_d           = 8'd0;
        dy_d           = 8'd0;
        dx_neg_d       = dx_neg_q;
        dy_neg_d       = dy_neg_q;
        buttons_d      = buttons_q;
        packet_valid_d = 1'b0;
        sync_err_d     = 1'b0;

        if (i_byte_valid) begin
            case (eff_state)
                WAIT_B0: begin
                    if (i_byte[B0_SYNC]) begin
                        b0_d    = i_byte;
                        state_d = WAIT_B1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                WAIT_B1: begin
                    x_d     = i_byte;
                    state_d = WAIT_B2;
                end
                WAIT_B2: begin
                    dx_d           = x_mag_dz;
                    dy_d           = y_mag_dz;
                    dx_neg_d       = x_neg;
                    dy_neg_d       = y_neg;
                    buttons_d      = buttons_t'({b0_q[B0_M], b0_q[B0_R], b0_q[B0_L]});
                    packet_valid_d = 1'b1;
                    state_d        = WAIT_B0;
                end
                default: state_d = WAIT_B0;
            endcase
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (i_byte_valid || timeout) begin
            idle_d = '0;
        end else if ((state_q != WAIT_B0) && (idle_q != CNT_MAX)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_B0;
            idle_q         <= '0;
            b0_q           <= 8'd0;
            x_q            <= 8'd0;
            dx_q           <= 8'd0;
            dy_q           <= 8'd0;
            dx_neg_q       <= 1'b0;
            dy_neg_q       <= 1'b0;
            buttons_q      <= '0;
            packet_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_q         <= idle_d;
            b0_q           <= b0_d;
            x_q            <= x_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            dx_neg_q       <= dx_neg_d;
            dy_neg_q       <= dy_neg_d;
            buttons_q      <= buttons_d;
            packet_valid_q <= packet_valid_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign o_mouse_dx        = dx_q;
    assign o_mouse_dy        = dy_q;
    assign o_is_mouse_dx_neg = dx_neg_q;
    assign o_is_mouse_dy_neg = dy_neg_q;
    assign o_buttons         = buttons_q;
    assign o_packet_valid    = packet_valid_q;
    assign o_sync_err        = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// tb/tb_ps2_mouse_packet_decoder.sv - scoreboard bench for the PS/2 mouse packet decoder
module tb_ps2_mouse_packet_decoder;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_byte = 8'd0;
    logic       i_byte_valid = 1'b0;
    logic [7:0] o_mouse_dx;
    logic [7:0] o_mouse_dy;
    logic       o_is_mouse_dx_neg;
    logic       o_is_mouse_dy_neg;
    logic [2:0] o_buttons;
    logic       o_packet_valid;
    logic       o_sync_err;

    typedef struct packed {
        logic [7:0] dx;
        logic [7:0] dy;
        logic       dxn;
        logic       dyn;
        logic [2:0] btn;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sync_seen = 0;
    int   sync_exp  = 0;
    int   pkt_seen  = 0;
    int   pkt_exp   = 0;
    bit   mon_en    = 1'b0;

    ps2_mouse_packet_decoder #(
        .TIMEOUT_CYCLES (TMO),
        .DEADZONE       (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_byte            (i_byte),
        .i_byte_valid      (i_byte_valid),
        .o_mouse_dx        (o_mouse_dx),
        .o_mouse_dy        (o_mouse_dy),
        .o_is_mouse_dx_neg (o_is_mouse_dx_neg),
        .o_is_mouse_dy_neg (o_is_mouse_dy_neg),
        .o_buttons         (o_buttons),
        .o_packet_valid    (o_packet_valid),
        .o_sync_err        (o_sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_mag(input bit sgn, input bit ovf, input logic [7:0] data);
        int v;
        v = sgn ? int'(data) - 256 : int'(data);
        if (v < 0) v = -v;
        if (ovf || v > 255) return 8'hFF;
        return 8'(v);
    endfunction

    task automatic send(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b0, input logic [7:0] bx, input logic [7:0] by);
        pkt_t p;
        p.dx  = model_mag(b0[4], b0[6], bx);
        p.dy  = model_mag(b0[5], b0[7], by);
        p.dxn = b0[4];
        p.dyn = b0[5];
        p.btn = {b0[2], b0[1], b0[0]};
        exp_q.push_back(p);
        pkt_exp++;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] bx, input logic [7:0] by);
        send(b0);
        send(bx);
        push_exp(b0, bx, by);
        send(by);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_sync_err) sync_seen++;
            if (o_packet_valid) begin
                pkt_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", 32'd1, 32'd0);
                end else begin
                    pkt_t e;
                    e = exp_q.pop_front();
                    check("dx",      32'(o_mouse_dx),        32'(e.dx));
                    check("dy",      32'(o_mouse_dy),        32'(e.dy));
                    check("dx_neg",  32'(o_is_mouse_dx_neg), 32'(e.dxn));
                    check("dy_neg",  32'(o_is_mouse_dy_neg), 32'(e.dyn));
                    check("buttons", 32'(o_buttons),         32'(e.btn));
                end
            end else begin
                check("idle_mag_zero", {o_mouse_dx, o_mouse_dy}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {o_mouse_dx, o_mouse_dy, 9'd0, o_is_mouse_dx_neg, o_is_mouse_dy_neg,
               o_buttons, o_packet_valid, o_sync_err}, 32'd0);
        mon_en = 1'b1;
        #1;

        send_pkt(8'h08, 8'h05, 8'h03);
        idle(2);
        send_pkt(8'h48, 8'h10, 8'h10);
        idle(2);

        send(8'h00);
        sync_exp++;
        @(negedge clk);
        check("sync_err_pulse", 32'(o_sync_err), 32'd1);
        #1;
        send_pkt(8'h08, 8'h01, 8'h01);
        idle(2);

        // Byte on the exact timeout cycle restarts as byte 0.
        send(8'h08);
        send(8'h07);
        idle(TMO);
        send_pkt(8'h08, 8'h02, 8'h02);
        idle(2);

        // One cycle short of timeout: the byte still completes the packet.
        send(8'h08);
        send(8'h07);
        idle(TMO - 1);
        push_exp(8'h08, 8'h07, 8'h09);
        send(8'h09);
        idle(2);

        send_pkt(8'h39, 8'hFB, 8'h00);
        idle(1);
        check("held_dx_neg",  32'(o_is_mouse_dx_neg), 32'd1);
        check("held_buttons", 32'(o_buttons),         32'd1);

        send(8'h0F);
        send(8'h07);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midpkt_reset_outputs",
              {o_mouse_dx, o_mouse_dy, 9'd0, o_is_mouse_dx_neg, o_is_mouse_dy_neg,
               o_buttons, o_packet_valid, o_sync_err}, 32'd0);
        #1;
        send(8'h01);
        sync_exp++;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] b0;
            b0 = 8'($urandom) | 8'h08;
            send_pkt(b0, 8'($urandom), 8'($urandom));
        end
        send_pkt(8'h28, 8'h00, 8'h00);
        send_pkt(8'h18, 8'h80, 8'h7F);
        idle(4);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("pkt_count",   32'(pkt_seen),     32'(pkt_exp));
        check("sync_count",  32'(sync_seen),    32'(sync_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Assembles the PS/2 mouse byte stream into 3-byte movement packets and converts each axis into the magnitude-plus-sign form consumed by the game engines (`i_mouse_dx`, `i_mouse_dy`, `i_is_mouse_dx_neg`, `i_is_mouse_dy_neg`). It sits between the PS/2 byte receiver and the game engines. The engines integrate `dx` every cycle, so the decoder presents a non-zero magnitude for exactly one cycle per packet.

## Interface
- `TIMEOUT_CYCLES`, 50000: max idle cycles between bytes of one packet before resync.
- `DEADZONE`, 1: magnitudes strictly below this are forced to 0 (only with `PS2_MOUSE_DEADZONE_EN`).
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `i_byte` in 8: received PS/2 byte.
- `i_byte_valid` in 1: one-cycle strobe, `i_byte` valid.
- `o_mouse_dx` out 8: |X| for one cycle on packet, else 0.
- `o_mouse_dy` out 8: |Y| for one cycle on packet, else 0.
- `o_is_mouse_dx_neg` out 1: X sign of last packet, held.
- `o_is_mouse_dy_neg` out 1: Y sign of last packet, held.
- `o_buttons` out 3: {M,R,L} of last packet, held.
- `o_packet_valid` out 1: one-cycle strobe, new packet presented.
- `o_sync_err` out 1: one-cycle strobe, byte 0 rejected.

## Operation
- FSM states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`. Reset state is `WAIT_B0`.
- In `WAIT_B0`, on `i_byte_valid`:
  - If bit3 = 1: latch flags and go to `WAIT_B1`.
  - If bit3 = 0: drop the byte, pulse `o_sync_err`, stay in `WAIT_B0`.
- Byte 0 layout: b0 L, b1 R, b2 M, b3 always 1, b4 X sign, b5 Y sign, b6 X overflow, b7 Y overflow.
- `WAIT_B1`: on a valid byte, latch X[7:0] and go to `WAIT_B2`.
- `WAIT_B2`: on a valid byte, latch Y[7:0], emit the packet, go to `WAIT_B0`.
- Axis conversion (per axis, 9-bit two's complement {sign, data}):
  - Overflow bit set: magnitude = 255, sign = sign bit.
  - Negative: magnitude = 9-bit negation truncated to 8 bits, saturating at 255 (−256 → 255).
  - Positive: magnitude = data.
  - Value 0 with sign 1 (−256 data 0x00) follows the negative rule → 255.
- Timeout: an idle counter clears on every `i_byte_valid`. It increments only in `WAIT_B1`/`WAIT_B2`. When it reaches `TIMEOUT_CYCLES`, the FSM returns to `WAIT_B0` and the partial packet is discarded.
- Timeout and `i_byte_valid` in the same cycle: resync takes priority, and the byte is evaluated as byte 0 in that same cycle.
- Reset mid-packet: the partial packet is discarded and no `o_packet_valid` is produced.

## Timing
- Every output resets to 0. The FSM resets to `WAIT_B0` and the idle counter to 0.
- Latency: `o_packet_valid`, non-zero `o_mouse_dx`/`o_mouse_dy`, and updated signs/buttons all appear on the cycle after the third byte's `i_byte_valid`.
- Signs and buttons update on that same edge and hold until the next packet.
- `o_sync_err` is asserted on the cycle after the offending byte.
- No backpressure: every strobe is consumed.
- Back-to-back strobes on consecutive cycles are legal, giving packets at full rate.
- Width rules:
  - The idle counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
  - Magnitude arithmetic is done at 9 bits and then clamped to 8.

## Configuration
- `PS2_MOUSE_DEADZONE_EN` defined: after conversion, any magnitude < `DEADZONE` is forced to 0. The sign is still updated.
- Undefined: magnitudes pass through unchanged and `DEADZONE` is ignored.

## Structure
- Package `ps2_mouse_pkg` holds:
  - FSM state enum.
  - Byte-0 bit index constants (`B0_L`…`B0_YOVF`, `B0_SYNC = 3`).
  - The 3-bit button type.
- Sub-module `ps2_mouse_axis_mag`: combinational {sign, data, ovf} → {mag[7:0], neg}, instantiated once per axis.

## Test plan
- Packet 0x08, 0x05, 0x03 → one cycle later: `o_packet_valid` = 1, `dx` = 5, `dy` = 3, both neg = 0, buttons = 0; next cycle `dx` = `dy` = 0.
- Packet 0x39, 0xFB, 0x00 (X = −5, Y = −256, L pressed) → `dx` = 5, dx_neg = 1, `dy` = 255, dy_neg = 1, buttons = 3'b001.
- Packet 0x48, 0x10, 0x10 (X overflow) → `dx` = 255, dx_neg = 0, `dy` = 16.
- Byte 0x00 in `WAIT_B0` → `o_sync_err` pulse, state stays `WAIT_B0`. The following 0x08, 0x01, 0x01 decodes normally.
- Send 0x08, 0x07, then idle `TIMEOUT_CYCLES`, then 0x08, 0x02, 0x02 → exactly one packet, `dx` = 2, `dy` = 2.
- Assert `rst` between byte 1 and byte 2 → no packet. All outputs read 0 the cycle after `rst`.
